// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO draining stores to DMEM, IMEM and UART TX.
//
// Ports:
//   clk, rst (async, active-high).
//   st_valid/st_ready/st_addr/st_data/st_wea/imem_on: store enqueue side.
//     The target region is decoded here and stored with the entry.
//   ld_req: a core load owns the DMEM port this cycle.
//   dmem_addr/dmem_din/dmem_we, imem_addr/imem_din/imem_we: write ports,
//     driven from the FIFO head only.
//   uart_tx_data/uart_tx_valid/uart_tx_ready: UART TX byte handshake.
//   empty: no pending stores.
//   stat_stores/stat_full_cycles: present only when WBUF_STATS_EN is defined.
//
// Optional feature macro: WBUF_STATS_EN adds the enqueue and full-stall counters.
module store_write_buffer #(
  parameter int DEPTH   = 4,
  parameter int DMEM_AW = 14,
  parameter int IMEM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  input  logic [3:0]         st_wea,
  input  logic               imem_on,
  input  logic               ld_req,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  output logic [3:0]         dmem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_din,
  output logic [3:0]         imem_we,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_valid,
  input  logic               uart_tx_ready,
  output logic               empty
`ifdef WBUF_STATS_EN
  ,
  output logic [31:0]        stat_stores,
  output logic [31:0]        stat_full_cycles
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = DMEM_AW > IMEM_AW ? DMEM_AW : IMEM_AW;
  // Only the word-address bits are kept; the region is fully decoded at enqueue.
  logic [AW-1:0] a_q [DEPTH];
  logic [31:0]   d_q [DEPTH];
  logic [3:0]    w_q [DEPTH];
  logic [2:0]    r_q [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;
  logic [2:0]    st_reg, h_r;
  logic          push, pop, to_d, to_i, to_u;
  // Region bits: [0]=DMEM, [1]=IMEM, [2]=UART; all zero means the store is dropped.
  assign st_reg = {st_addr == 32'h8000_0008,
                   !st_addr[31] && st_addr[29] && imem_on,
                   !st_addr[31] && st_addr[28]};
  assign empty    = cnt == '0;
  assign st_ready = cnt != (PW+1)'(DEPTH);
  assign push     = st_valid && st_ready && |st_wea;
  assign h_r      = empty ? 3'b000 : r_q[rp];
  assign to_d     = h_r[0];
  assign to_i     = h_r[1];
  assign to_u     = h_r[2];
  // A two-target head only retires when every target is served at once.
  assign pop = !empty && !(to_d && ld_req) && !(to_u && !uart_tx_ready);
  always_comb begin
    dmem_addr     = to_d ? a_q[rp][DMEM_AW-1:0] : '0;
    dmem_din      = to_d ? d_q[rp] : '0;
    dmem_we       = pop && to_d ? w_q[rp] : 4'b0;
    imem_addr     = to_i ? a_q[rp][IMEM_AW-1:0] : '0;
    imem_din      = to_i ? d_q[rp] : '0;
    imem_we       = pop && to_i ? w_q[rp] : 4'b0;
    uart_tx_valid = to_u;
    uart_tx_data  = to_u ? d_q[rp][7:0] : 8'h00;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) begin
      a_q[wp] <= st_addr[AW+1:2];
      d_q[wp] <= st_data;
      w_q[wp] <= st_wea;
      r_q[wp] <= st_reg;
    end
`ifdef WBUF_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_stores      <= '0;
      stat_full_cycles <= '0;
    end else begin
      if (push) stat_stores <= stat_stores + 32'd1;
      if (st_valid && !st_ready) stat_full_cycles <= stat_full_cycles + 32'd1;
    end
`endif
endmodule
